// File: rtl/ctrl_ramdrv_sched_pkg.sv
// Shared definitions for the RAM-driver scheduler: FSM state encoding,
// header command strobe encoding and the statistics counter width.
// Optional feature macro used by the top: RAMDRV_SCHED_STAT_EN.
package ctrl_ramdrv_sched_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_INIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_INCR  = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic clr;
        logic init;
        logic read;
        logic incr;
    } hdr_cmd_t;

    localparam hdr_cmd_t HDR_CMD_NONE = 4'b0000;
    localparam hdr_cmd_t HDR_CMD_CLR  = 4'b1000;
    localparam hdr_cmd_t HDR_CMD_INIT = 4'b0100;
    localparam hdr_cmd_t HDR_CMD_READ = 4'b0010;
    localparam hdr_cmd_t HDR_CMD_INCR = 4'b0001;

    localparam int STAT_WIDTH = 16;

    // Each state issues at most one header command; this keeps the strobes
    // mutually exclusive by construction.
    function automatic hdr_cmd_t hdr_cmd_of(input sched_state_t s);
        case (s)
            ST_CLEAR: return HDR_CMD_CLR;
            ST_INIT:  return HDR_CMD_INIT;
            ST_READ:  return HDR_CMD_READ;
            ST_INCR:  return HDR_CMD_INCR;
            default:  return HDR_CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_ramdrv_sched_arbiter.sv
// Round-robin arbiter: the search starts one channel past the pointer and
// wraps, so the pointer channel itself has the lowest priority.
module ctrl_rr_arbiter
    import ctrl_ramdrv_sched_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    localparam int NCH = 2 ** INDEX_WIDTH
) (
    input  logic [NCH-1:0]         req,
    input  logic [INDEX_WIDTH-1:0] pointer,
    output logic [NCH-1:0]         grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   any
);

    logic [INDEX_WIDTH-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest requester overwrites.
    always_comb begin
        grant_index = '0;
        any         = 1'b0;
        cand        = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = pointer + INDEX_WIDTH'(i);
            if (req[cand]) begin
                grant_index = cand;
                any         = 1'b1;
            end
        end
    end

    assign grant = any ? (NCH'(1) << grant_index) : '0;

endmodule

// File: rtl/ctrl_ramdrv_sched.sv
// RAM-driver scheduler: serialises per-channel sample writes into a shared
// RAM, using an external header block for per-channel write offsets.
// Optional: define RAMDRV_SCHED_STAT_EN to enable the stat_writes counter.
module ctrl_ramdrv_sched
    import ctrl_ramdrv_sched_pkg::*;
#(
    parameter int OFFSET_WIDTH = 10,
    parameter int INDEX_WIDTH  = 4,
    parameter int DATA_WIDTH   = 16,
    localparam int NCH = 2 ** INDEX_WIDTH
) (
    input  logic                              clk,
    input  logic                              clr_n,
    input  logic                              soft_clr,
    input  logic                              cfg_valid,
    input  logic [OFFSET_WIDTH-1:0]           cfg_length,
    output logic                              cfg_ack,
    input  logic [NCH-1:0]                    req,
    input  logic [NCH*DATA_WIDTH-1:0]         req_data,
    output logic [NCH-1:0]                    ack,
    output logic                              hdr_clr,
    output logic                              hdr_init,
    output logic                              hdr_read,
    output logic                              hdr_incr,
    output logic [INDEX_WIDTH-1:0]            hdr_index,
    output logic [OFFSET_WIDTH-1:0]           hdr_length,
    input  logic [OFFSET_WIDTH-1:0]           hdr_offset,
    output logic                              ram_we,
    output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]             ram_wdata,
    output logic                              busy,
    output logic [STAT_WIDTH-1:0]             stat_writes
);

    sched_state_t            state, next_state;
    hdr_cmd_t                cmd;
    logic [INDEX_WIDTH-1:0]  grant_q;
    logic [NCH-1:0]          grant_oh_q;
    logic [INDEX_WIDTH-1:0]  last_granted;
    logic [OFFSET_WIDTH-1:0] cfg_len_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic [NCH-1:0]          arb_grant;
    logic [INDEX_WIDTH-1:0]  arb_index;
    logic                    arb_any;

    ctrl_rr_arbiter #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_arbiter (
        .req         (req),
        .pointer     (last_granted),
        .grant       (arb_grant),
        .grant_index (arb_index),
        .any         (arb_any)
    );

    // State register; reset parks in CLEAR so the header gets cleared on release.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; IDLE priority is soft clear, then configuration, then requests.
    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: next_state = ST_IDLE;
            ST_IDLE: begin
                if (soft_clr) begin
                    next_state = ST_CLEAR;
                end else if (cfg_valid) begin
                    next_state = ST_INIT;
                end else if (arb_any) begin
                    next_state = ST_READ;
                end
            end
            ST_INIT:  next_state = ST_IDLE;
            ST_READ:  next_state = ST_WRITE;
            ST_WRITE: next_state = ST_INCR;
            ST_INCR:  next_state = ST_IDLE;
            default:  next_state = ST_CLEAR;
        endcase
    end

    // Moore outputs; hdr_clr is qualified by clr_n so it stays low while reset is held.
    always_comb begin
        cmd        = hdr_cmd_of(state);
        hdr_clr    = cmd.clr & clr_n;
        hdr_init   = cmd.init;
        hdr_read   = cmd.read;
        hdr_incr   = cmd.incr;
        cfg_ack    = 1'b0;
        hdr_length = '0;
        hdr_index  = '0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ack        = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_INIT: begin
                cfg_ack    = 1'b1;
                hdr_length = cfg_len_q;
            end
            ST_READ: begin
                hdr_index = grant_q;
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = {grant_q, offset_q};
                ram_wdata = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_INCR: begin
                hdr_index = grant_q;
                ack       = grant_oh_q;
            end
            default: ;
        endcase
    end

    // Capture the IDLE decision (config length or grant) and the header offset read back in READ.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            grant_q      <= '0;
            grant_oh_q   <= '0;
            last_granted <= '1;
            cfg_len_q    <= '0;
            offset_q     <= '0;
        end else begin
            if (state == ST_IDLE && !soft_clr) begin
                if (cfg_valid) begin
                    cfg_len_q <= cfg_length;
                end else if (arb_any) begin
                    grant_q      <= arb_index;
                    grant_oh_q   <= arb_grant;
                    last_granted <= arb_index;
                end
            end
            if (state == ST_READ) begin
                offset_q <= hdr_offset;
            end
        end
    end

`ifdef RAMDRV_SCHED_STAT_EN
    logic [STAT_WIDTH-1:0] stat_q;

    // Saturating count of completed writes, restarted whenever the header is cleared.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stat_q <= '0;
        end else if (state == ST_CLEAR) begin
            stat_q <= '0;
        end else if (state == ST_INCR && stat_q != '1) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign stat_writes = stat_q;
`else
    assign stat_writes = '0;
`endif

endmodule
